// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Brief    : Shared constants for the Wishbone round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_ABORT = 2'd2;

    localparam int c_WDOG_W = 16;

    localparam logic [31:0] c_TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin picker; search starts one past i_last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    int                 w_cand;
    logic [IDX_W-1:0]   w_cidx;
    logic               w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_cand  = 0;
        w_cidx  = '0;
        w_found = 1'b0;
        // Wrap-around without a modulo so non-power-of-two counts stay cheap.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(i_last) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cidx = IDX_W'(w_cand);
            if (!w_found && i_req[w_cidx]) begin
                w_found       = 1'b1;
                o_gnt[w_cidx] = 1'b1;
                o_idx         = w_cidx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Brief    : Round-robin Wishbone B4 classic arbiter with no-ack watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int                NUM_MASTERS  = 2,
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    localparam int               SEL_W        = DATA_W / 8,
    parameter int                TIMEOUT      = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(c_TIMEOUT_DATA_DEFAULT)
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    output logic [DATA_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [ADDR_W-1:0]             s_adr_o,
    output logic [DATA_W-1:0]             s_dat_o,
    output logic [SEL_W-1:0]              s_sel_o,
    output logic                          s_we_o,
    output logic                          s_stb_o,
    output logic                          s_cyc_o,
    input  logic [DATA_W-1:0]             s_dat_i,
    input  logic                          s_ack_i,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic                          timeout_o
);

    localparam int                  c_IDX_W      = $clog2(NUM_MASTERS);
    localparam logic [c_IDX_W-1:0]  c_LAST_RST   = c_IDX_W'(NUM_MASTERS - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LIMIT = c_WDOG_W'(TIMEOUT - 1);

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [c_IDX_W-1:0]     r_last;
    logic [c_WDOG_W-1:0]    r_wdog;
    logic                   r_timeout;

    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic [c_IDX_W-1:0]     w_pick_idx;
    logic [ADDR_W-1:0]      w_adr;
    logic [DATA_W-1:0]      w_wdat;
    logic [SEL_W-1:0]       w_sel;
    logic                   w_we;
    logic                   w_owner_cyc;
    logic                   w_owner_stb;
    logic                   w_in_grant;
    logic                   w_in_abort;
    logic                   w_fire;

    rr_priority_picker #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (c_IDX_W)
    ) u_picker (
        .i_req  (m_cyc_i),
        .i_last (r_last),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx)
    );

    // AND-OR mux on the one-hot grant; an empty grant yields an all-zero bus.
    always_comb begin
        w_adr       = '0;
        w_wdat      = '0;
        w_sel       = '0;
        w_we        = 1'b0;
        w_owner_cyc = 1'b0;
        w_owner_stb = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) begin
                w_adr       = w_adr  | m_adr_i[k*ADDR_W +: ADDR_W];
                w_wdat      = w_wdat | m_dat_i[k*DATA_W +: DATA_W];
                w_sel       = w_sel  | m_sel_i[k*SEL_W +: SEL_W];
                w_we        = w_we        | m_we_i[k];
                w_owner_cyc = w_owner_cyc | m_cyc_i[k];
                w_owner_stb = w_owner_stb | m_stb_i[k];
            end
        end
    end

    assign w_in_grant = (r_state == c_GRANT);
    assign w_in_abort = (r_state == c_ABORT);

    assign s_adr_o   = w_adr;
    assign s_dat_o   = w_wdat;
    assign s_sel_o   = w_sel;
    assign s_we_o    = w_we;
    assign s_cyc_o   = w_in_grant & w_owner_cyc;
    assign s_stb_o   = w_in_grant & w_owner_stb;
    assign m_ack_o   = w_in_abort ? r_grant
                     : (w_in_grant ? (r_grant & {NUM_MASTERS{s_ack_i}}) : '0);
    assign m_err_o   = w_in_abort ? r_grant : '0;
    assign m_dat_o   = w_in_abort ? TIMEOUT_DATA : s_dat_i;
    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

    // A late ack in the terminal counting cycle suppresses the abort.
    assign w_fire = w_owner_cyc & s_stb_o & ~s_ack_i & (r_wdog == c_WDOG_LIMIT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= c_IDLE;
            r_grant   <= '0;
            r_last    <= c_LAST_RST;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|w_pick_gnt) begin
                        r_grant <= w_pick_gnt;
                        r_last  <= w_pick_idx;
                        r_state <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    if (!w_owner_cyc) begin
                        r_grant <= '0;
                        r_state <= c_IDLE;
                    end else if (w_fire) begin
                        r_timeout <= 1'b1;
                        r_state   <= c_ABORT;
                    end
                end
                c_ABORT: begin
                    r_state <= c_GRANT;
                end
                default: begin
                    r_grant <= '0;
                    r_state <= c_IDLE;
                end
            endcase

            if (!w_in_grant || w_fire || !s_stb_o || s_ack_i) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rr_arbiter
// Brief    : Self-checking bench for wb_rr_arbiter (3 masters, TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

    localparam int N  = 3;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*32-1:0] m_adr, m_wdat;
    logic [N*4-1:0]  m_sel;
    logic [N-1:0]    m_we, m_stb, m_cyc;
    logic [31:0]     m_rdat;
    logic [N-1:0]    m_ack, m_err;
    logic [31:0]     s_adr, s_wdat, s_rdat;
    logic [3:0]      s_sel;
    logic            s_we, s_stb, s_cyc, s_ack;
    logic [N-1:0]    grant;
    logic            tmo;
    logic [3*N+1:0]  st;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int md_owner, md_last, md_stall;
    bit md_abort, md_tflag;

    always #5 clk = ~clk;

    assign st = {grant, s_cyc, s_stb, m_ack, m_err};

    wb_rr_arbiter #(
        .NUM_MASTERS  (N),
        .ADDR_W       (32),
        .DATA_W       (32),
        .TIMEOUT      (TO),
        .TIMEOUT_DATA (32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_wdat),
        .m_sel_i   (m_sel),
        .m_we_i    (m_we),
        .m_stb_i   (m_stb),
        .m_cyc_i   (m_cyc),
        .m_dat_o   (m_rdat),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_wdat),
        .s_sel_o   (s_sel),
        .s_we_o    (s_we),
        .s_stb_o   (s_stb),
        .s_cyc_o   (s_cyc),
        .s_dat_i   (s_rdat),
        .s_ack_i   (s_ack),
        .grant_o   (grant),
        .timeout_o (tmo)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        s_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        s_rdat = 32'h1111_2222;
        tick();
        tick();
        #1;
        n_cmp++;
        if (st !== '0) begin
            n_bad++;
            $display("FAIL reset_status: status=%b expected all zero", st);
        end
        n_cmp++;
        if (tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_timeout: timeout_o=%b expected 0", tmo);
        end
        n_cmp++;
        if (s_adr !== '0 || s_wdat !== '0 || s_sel !== '0 || s_we !== 1'b0 || m_rdat !== 32'h1111_2222) begin
            n_bad++;
            $display("FAIL reset_bus: adr=%h dat=%h sel=%h we=%b m_dat=%h expected zeros and m_dat=11112222",
                     s_adr, s_wdat, s_sel, s_we, m_rdat);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        tick();
        m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b010;
        m_adr  = {32'h0, 32'h0000_0040, 32'hFFFF_0000};
        m_wdat = {32'h0, 32'h1234_5678, 32'hAAAA_5555};
        m_sel  = {4'h0, 4'hF, 4'h3};
        #1;
        n_cmp++;
        if (st !== '0) begin
            n_bad++;
            $display("FAIL single_arb_cycle: status=%b expected all zero", st);
        end
        tick();
        #1;
        n_cmp++;
        if (st !== 11'b010_11_000_000) begin
            n_bad++;
            $display("FAIL single_grant: status=%b expected %b", st, 11'b010_11_000_000);
        end
        n_cmp++;
        if (s_adr !== 32'h0000_0040 || s_wdat !== 32'h1234_5678 || s_sel !== 4'hF || s_we !== 1'b1) begin
            n_bad++;
            $display("FAIL single_bus: adr=%h dat=%h sel=%h we=%b expected 00000040 12345678 f 1",
                     s_adr, s_wdat, s_sel, s_we);
        end
        tick();
        s_ack = 1'b1; s_rdat = 32'hCAFE_0001;
        #1;
        n_cmp++;
        if (st !== 11'b010_11_010_000 || m_rdat !== 32'hCAFE_0001) begin
            n_bad++;
            $display("FAIL single_ack: status=%b m_dat=%h expected %b cafe0001", st, m_rdat, 11'b010_11_010_000);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (st !== 11'b010_00_000_000) begin
            n_bad++;
            $display("FAIL single_release: status=%b expected %b", st, 11'b010_00_000_000);
        end
        tick();
        #1;
        n_cmp++;
        if (st !== '0) begin
            n_bad++;
            $display("FAIL single_idle: status=%b expected all zero", st);
        end
    endtask

    task automatic test_alternate();
        logic [2:0]  t_cyc [10] = '{3'b011, 3'b011, 3'b010, 3'b011, 3'b011,
                                    3'b001, 3'b011, 3'b011, 3'b000, 3'b000};
        logic        t_ack [10] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        logic [10:0] t_exp [10] = '{11'b000_00_000_000, 11'b001_11_001_000, 11'b001_00_000_000,
                                    11'b000_00_000_000, 11'b010_11_010_000, 11'b010_00_000_000,
                                    11'b000_00_000_000, 11'b001_11_001_000, 11'b001_00_000_000,
                                    11'b000_00_000_000};
        for (int i = 0; i < 10; i++) begin
            tick();
            m_cyc = t_cyc[i]; m_stb = t_cyc[i]; s_ack = t_ack[i];
            #1;
            n_cmp++;
            if (st !== t_exp[i]) begin
                n_bad++;
                $display("FAIL alternate[%0d]: status=%b expected %b", i, st, t_exp[i]);
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [2:0]  t_cyc [10] = '{3'b001, 3'b011, 3'b011, 3'b011, 3'b011,
                                    3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        logic        t_ack [10] = '{0, 1, 1, 1, 1, 0, 0, 1, 0, 0};
        logic [10:0] t_exp [10] = '{11'b000_00_000_000, 11'b001_11_001_000, 11'b001_11_001_000,
                                    11'b001_11_001_000, 11'b001_11_001_000, 11'b001_00_000_000,
                                    11'b000_00_000_000, 11'b010_11_010_000, 11'b010_00_000_000,
                                    11'b000_00_000_000};
        for (int i = 0; i < 10; i++) begin
            tick();
            m_cyc = t_cyc[i]; m_stb = t_cyc[i]; s_ack = t_ack[i];
            #1;
            n_cmp++;
            if (st !== t_exp[i]) begin
                n_bad++;
                $display("FAIL no_preempt[%0d]: status=%b expected %b", i, st, t_exp[i]);
            end
        end
    endtask

    task automatic test_ack_at_limit();
        logic [2:0]  t_cyc [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        logic        t_ack [7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [10:0] t_exp [7] = '{11'b000_00_000_000, 11'b001_11_000_000, 11'b001_11_000_000,
                                   11'b001_11_000_000, 11'b001_11_001_000, 11'b001_00_000_000,
                                   11'b000_00_000_000};
        m_we = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            m_cyc = t_cyc[i]; m_stb = t_cyc[i]; s_ack = t_ack[i];
            #1;
            n_cmp++;
            if (st !== t_exp[i] || tmo !== 1'b0) begin
                n_bad++;
                $display("FAIL ack_at_limit[%0d]: status=%b timeout=%b expected %b 0", i, st, tmo, t_exp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [2:0]  t_cyc [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        logic [10:0] t_exp [8] = '{11'b000_00_000_000, 11'b001_11_000_000, 11'b001_11_000_000,
                                   11'b001_11_000_000, 11'b001_11_000_000, 11'b001_00_001_001,
                                   11'b001_00_000_000, 11'b000_00_000_000};
        logic [31:0] e_dat;
        s_rdat = 32'h0BAD_F00D;
        s_ack  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            m_cyc = t_cyc[i]; m_stb = t_cyc[i];
            #1;
            e_dat = (i == 5) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
            n_cmp++;
            if (st !== t_exp[i] || m_rdat !== e_dat) begin
                n_bad++;
                $display("FAIL timeout[%0d]: status=%b m_dat=%h expected %b %h", i, st, m_rdat, t_exp[i], e_dat);
            end
            if (i != 5) begin
                n_cmp++;
                if (tmo !== (i > 5)) begin
                    n_bad++;
                    $display("FAIL timeout_flag[%0d]: timeout_o=%b expected %b", i, tmo, (i > 5));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0]  t_cyc [6] = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b000, 3'b000};
        logic        t_rst [6] = '{0, 1, 0, 0, 0, 0};
        logic        t_ack [6] = '{0, 0, 1, 0, 0, 0};
        logic [10:0] t_exp [6] = '{11'b000_00_000_000, 11'b001_11_000_000, 11'b000_00_000_000,
                                   11'b001_11_000_000, 11'b001_00_000_000, 11'b000_00_000_000};
        for (int i = 0; i < 6; i++) begin
            tick();
            m_cyc = t_cyc[i]; m_stb = t_cyc[i]; s_ack = t_ack[i]; rst = t_rst[i];
            #1;
            n_cmp++;
            if (st !== t_exp[i]) begin
                n_bad++;
                $display("FAIL reset_mid[%0d]: status=%b expected %b", i, st, t_exp[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if (tmo !== 1'b0 || s_adr !== '0) begin
                    n_bad++;
                    $display("FAIL reset_mid_clear: timeout_o=%b adr=%h expected 0 0", tmo, s_adr);
                end
            end
        end
    endtask

    task automatic test_random();
        int          ack_pct = 50;
        int          cand;
        logic [31:0] rnd;
        logic [N-1:0] e_grant, e_ack, e_err;
        logic        e_cyc, e_stb;
        logic [31:0] e_dat;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (i % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ack_pct = 0;
                    1:       ack_pct = 25;
                    default: ack_pct = 80;
                endcase
            end
            rst = (i == 0) || ($urandom_range(0, 99) == 0);
            for (int k = 0; k < N; k++) begin
                if (m_cyc[k]) begin
                    if ($urandom_range(0, 3) == 0) m_cyc[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc[k] = 1'b1;
                end
                rnd = $urandom;
                m_stb[k] = m_cyc[k] & (rnd[1:0] != 2'b00);
                m_we[k]  = rnd[2];
                m_sel[k*4 +: 4]   = rnd[7:4];
                m_adr[k*32 +: 32] = $urandom;
                m_wdat[k*32 +: 32] = $urandom;
            end
            s_ack  = ($urandom_range(0, 99) < ack_pct);
            s_rdat = $urandom;
            #1;

            // Expected outputs from the model's view of who owns the bus
            e_grant = '0; e_ack = '0; e_err = '0; e_cyc = 1'b0; e_stb = 1'b0; e_dat = s_rdat;
            if (md_owner >= 0) begin
                e_grant[md_owner] = 1'b1;
                if (md_abort) begin
                    e_ack[md_owner] = 1'b1;
                    e_err[md_owner] = 1'b1;
                    e_dat = 32'hDEAD_BEEF;
                end else begin
                    e_cyc = m_cyc[md_owner];
                    e_stb = m_stb[md_owner];
                    e_ack[md_owner] = s_ack;
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (st !== {e_grant, e_cyc, e_stb, e_ack, e_err}) begin
                    n_bad++;
                    $display("FAIL random_status[%0d]: status=%b expected %b", i, st, {e_grant, e_cyc, e_stb, e_ack, e_err});
                end
                n_cmp++;
                if (m_rdat !== e_dat || tmo !== md_tflag) begin
                    n_bad++;
                    $display("FAIL random_data[%0d]: m_dat=%h timeout=%b expected %h %b", i, m_rdat, tmo, e_dat, md_tflag);
                end
                if (md_owner >= 0 && !md_abort) begin
                    n_cmp++;
                    if (s_adr !== m_adr[md_owner*32 +: 32] || s_wdat !== m_wdat[md_owner*32 +: 32] ||
                        s_sel !== m_sel[md_owner*4 +: 4] || s_we !== m_we[md_owner]) begin
                        n_bad++;
                        $display("FAIL random_bus[%0d]: adr=%h dat=%h sel=%h we=%b owner=%0d",
                                 i, s_adr, s_wdat, s_sel, s_we, md_owner);
                    end
                end
            end

            // Advance the model across the coming clock edge
            if (rst) begin
                md_owner = -1; md_last = N - 1; md_stall = 0; md_abort = 0; md_tflag = 0;
            end else if (md_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    cand = (md_last + k) % N;
                    if (md_owner < 0 && m_cyc[cand]) begin
                        md_owner = cand;
                        md_last  = cand;
                    end
                end
                md_stall = 0;
            end else if (md_abort) begin
                md_abort = 0;
                md_stall = 0;
            end else if (!m_cyc[md_owner]) begin
                md_owner = -1;
                md_stall = 0;
            end else if (m_stb[md_owner] && !s_ack) begin
                md_stall++;
                if (md_stall == TO) begin
                    md_abort = 1;
                    md_tflag = 1;
                    md_stall = 0;
                end
            end else begin
                md_stall = 0;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        m_adr  = '0;
        m_wdat = '0;
        m_sel  = '0;
        s_rdat = '0;
        idle_inputs();
        md_owner = -1; md_last = N - 1; md_stall = 0; md_abort = 0; md_tflag = 0;

        test_reset();
        test_single_write();
        test_alternate();
        test_no_preempt();
        test_ack_at_limit();
        test_timeout();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
